calc_sched: RTL and testbench
=============================

CALC_SCHED -- requirements
Module: calc_sched

Interface
REQ-001 Parameter NREQ, 4, number of requesters sharing one calc unit (2..8).
REQ-002 Parameter TIMEOUT_CYC, 64, watchdog limit in cycles (used only with CALC_SCHED_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  NREQ  per-requester operation request.
REQ-006 req_a  in  8*NREQ  operand A per requester, slice i = [8i+7:8i].
REQ-007 req_b  in  8*NREQ  operand B per requester.
REQ-008 req_op  in  2*NREQ  op type per requester: 00 add, 01 sub, 10 mul, 11 div.
REQ-009 req_ready  out  NREQ  one-hot; request i is accepted in the cycle req_valid[i] and req_ready[i] are both high.
REQ-010 rsp_valid  out  NREQ  one-hot; result valid for requester i.
REQ-011 rsp_c  out  16  result shared by all requesters.
REQ-012 rsp_err  out  1  timeout flag qualifying rsp_valid; tied 0 without the macro.
REQ-013 rsp_ready  in  1  the requester owning rsp_valid accepts the result.
REQ-014 calc_inpA / calc_inpB / calc_inpOpType  out  8/8/2  calc operands and op type, registered.
REQ-015 calc_iValid  out  1  operation valid to calc.
REQ-016 calc_iStall  in  1  calc cannot accept a new operation.
REQ-017 calc_oValid / calc_outC  in  1/16  calc result valid and data.
REQ-018 calc_oStall  out  1  back-pressure to calc.

Function
REQ-019 FSM states: IDLE, ISSUE, DRAIN, RESP.
REQ-020 IDLE: if any req_valid and calc_iStall=0, grant exactly one requester by round-robin starting at rr_ptr.
- Assert req_ready for the grantee only, combinationally, in that cycle.
- Latch operands, op type and grant index.
- Go to ISSUE.
REQ-021 Round-robin: after each grant, rr_ptr = grant+1 mod NREQ. A single active requester is granted back-to-back.
REQ-022 ISSUE: calc_iValid=1 with stable operands until calc_oValid=1.
- In that cycle, capture calc_outC into rsp_c.
- Next cycle: drop calc_iValid and go to DRAIN.
REQ-023 DRAIN: wait for calc_oValid=0, then go to RESP. If calc_oValid is already 0, go to RESP in the next cycle.
REQ-024 RESP: rsp_valid[grant]=1 and rsp_c stable until rsp_ready=1, then return to IDLE.
REQ-025 The minimum turnaround from grant to rsp_valid is 3 cycles plus calc latency. No new grant is made before the RESP handshake completes.
REQ-026 calc_oStall=1 only in RESP while rsp_ready=0; otherwise 0.
REQ-027 req_ready is 0 in all states except IDLE, and 0 in IDLE while calc_iStall=1.
REQ-028 rsp_c is not recomputed. The calc result is passed through unmodified, including calc's 0 for divide-by-zero.
REQ-029 Requests deasserted before being granted are dropped silently. No request state is kept outside the grant cycle.

Reset
REQ-030 On rstn=0, asynchronously:
- state=IDLE, rr_ptr=0.
- req_ready=0, rsp_valid=0, rsp_c=0, rsp_err=0.
- calc_iValid=0, calc_oStall=0, calc operand outputs=0.
REQ-031 Reset during ISSUE/DRAIN/RESP abandons the operation; no response is issued after release.
REQ-032 The first grant after reset release occurs no earlier than the first posedge with rstn=1.

Configuration
REQ-033 Macro CALC_SCHED_TIMEOUT_EN, when defined: a cycle counter runs in ISSUE and DRAIN.
- At TIMEOUT_CYC cycles, force calc_iValid=0 and go to RESP with rsp_c=0 and rsp_err=1.
- The counter clears on entry to ISSUE.
REQ-034 Without the macro: no counter, rsp_err is constant 0, and ISSUE/DRAIN wait indefinitely.

Structure
REQ-035 Shared package calc_pkg holds:
- op-type constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
- the FSM state encoding;
- the operand width 8 and result width 16.
REQ-036 The round-robin picker is a sub-module calc_rr_arb (inputs: request vector, pointer; output: one-hot grant). The FSM, registers and watchdog stay in calc_sched.

Verification
REQ-037 Req0 A=05 B=05 op=00 -> req_ready[0] pulses once; rsp_valid[0] with rsp_c=000A.
REQ-038 Req0 and req2 valid in the same cycle, rr_ptr=0 -> req0 is served first, then req2; the next simultaneous pair starts at req3 (or wraps to 0).
REQ-039 Req1 A=07 B=11 op=10 -> rsp_c=0077. Req3 A=16 B=00 op=11 -> rsp_c=0000 with rsp_err=0.
REQ-040 rsp_ready held 0 for 3 cycles in RESP -> calc_oStall=1 and rsp_c stable for 3 cycles, and no req_ready asserts.
REQ-041 calc_iStall=1 with req_valid=1 -> no req_ready; grant occurs the cycle after calc_iStall falls.
REQ-042 With CALC_SCHED_TIMEOUT_EN, TIMEOUT_CYC=8 and calc_oValid held 0 -> rsp_err=1 and rsp_c=0000 after 8 cycles; a reset pulse mid-ISSUE yields IDLE and no rsp_valid.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calc scheduler: op codes, FSM encoding, datapath widths.
// Latency: none (package only).
// Backpressure: n/a.
package calc_pkg;

  // Datapath widths of the shared calc unit
  localparam int OPW  = 8;
  localparam int RESW = 16;

  // Operation codes carried on req_op / calc_inpOpType
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Scheduler FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // One latched operation as handed to the calc unit
  typedef struct packed {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [1:0]     op;
  } op_t;

endpackage

// File: rtl/calc_rr_arb.sv
// Round-robin picker: one-hot grant of the first set request at or after ptr.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module calc_rr_arb
  import calc_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt
);

  logic          found;
  logic [PW-1:0] idx;

  // Scan requesters starting at ptr, wrapping at NREQ, and keep the first hit
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_sched.sv
// Shares one calc unit among NREQ requesters; optional watchdog under CALC_SCHED_TIMEOUT_EN.
// Latency: grant to rsp_valid = 3 cycles + calc latency (+ cycles calc_oValid lingers).
// Backpressure: one op in flight; no grant until the response handshake; calc_oStall while rsp_ready=0.
module calc_sched
  import calc_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [OPW*NREQ-1:0]   req_a,
  input  logic [OPW*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]     req_op,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [RESW-1:0]       rsp_c,
  output logic                  rsp_err,
  input  logic                  rsp_ready,
  output logic [OPW-1:0]        calc_inpA,
  output logic [OPW-1:0]        calc_inpB,
  output logic [1:0]            calc_inpOpType,
  output logic                  calc_iValid,
  input  logic                  calc_iStall,
  input  logic                  calc_oValid,
  input  logic [RESW-1:0]       calc_outC,
  output logic                  calc_oStall
);

  localparam int PW = $clog2(NREQ);

  logic [1:0]      state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic [PW-1:0]   next_ptr;
  op_t             sel_op;
  logic            grant_fire;
  logic            wd_expired;
  logic            timeout_hit;

  calc_rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Encode the one-hot grant and mux out that requester's operands
  always_comb begin
    arb_idx = '0;
    sel_op  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (arb_gnt[k]) begin
        arb_idx   = PW'(k);
        sel_op.a  = req_a[k*OPW +: OPW];
        sel_op.b  = req_b[k*OPW +: OPW];
        sel_op.op = req_op[k*2 +: 2];
      end
    end
  end

  assign next_ptr   = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
  assign grant_fire = (state == ST_IDLE) && !calc_iStall && (req_valid != '0);
  // Gated by rstn so nothing looks accepted while reset is held
  assign req_ready  = (grant_fire && rstn) ? arb_gnt : '0;

  assign calc_iValid = (state == ST_ISSUE);
  assign calc_oStall = (state == ST_RESP) && !rsp_ready;

  // Decode the owner of the pending response into the one-hot rsp_valid
  always_comb begin
    rsp_valid = '0;
    for (int k = 0; k < NREQ; k++) begin
      rsp_valid[k] = (state == ST_RESP) && (gnt_idx == PW'(k));
    end
  end

  // Timeout only fires when the normal exit of ISSUE/DRAIN is not already taken
  assign timeout_hit = wd_expired &&
                       (((state == ST_ISSUE) && !calc_oValid) ||
                        ((state == ST_DRAIN) &&  calc_oValid));

`ifdef CALC_SCHED_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  logic [TOW-1:0] wd_cnt;

  assign wd_expired = (wd_cnt == TOW'(TIMEOUT_CYC - 1));

  // Watchdog: restart at grant, count every ISSUE/DRAIN cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt <= '0;
    end else if (grant_fire) begin
      wd_cnt <= '0;
    end else if (((state == ST_ISSUE) || (state == ST_DRAIN)) && !wd_expired) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Error flag belongs to the current op: cleared at grant, set on timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_err <= 1'b0;
    end else if (grant_fire) begin
      rsp_err <= 1'b0;
    end else if (timeout_hit) begin
      rsp_err <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC > 0);
  assign wd_expired = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Main scheduler: grant, issue, wait for calc to drop oValid, hold response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      gnt_idx        <= '0;
      calc_inpA      <= '0;
      calc_inpB      <= '0;
      calc_inpOpType <= '0;
      rsp_c          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            gnt_idx        <= arb_idx;
            rr_ptr         <= next_ptr;
            calc_inpA      <= sel_op.a;
            calc_inpB      <= sel_op.b;
            calc_inpOpType <= sel_op.op;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (calc_oValid) begin
            rsp_c <= calc_outC;
            state <= ST_DRAIN;
          end else if (timeout_hit) begin
            rsp_c <= '0;
            state <= ST_RESP;
          end
        end
        ST_DRAIN: begin
          if (!calc_oValid) begin
            state <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_c <= '0;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sched.sv
// Directed bench for calc_sched with a behavioural calc unit and a scoreboard model.
// The model predicts grants by round-robin over req_valid and results from request operands.
// Literal expectations pin ordering, results and latencies of the directed scenarios.
module tb_calc_sched;

  localparam int NREQ = 4;
  localparam int TO   = 8;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [2*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_c;
  logic              rsp_err;
  logic              rsp_ready;
  logic [7:0]        calc_inpA;
  logic [7:0]        calc_inpB;
  logic [1:0]        calc_inpOpType;
  logic              calc_iValid;
  logic              calc_iStall;
  logic              calc_oValid;
  logic [15:0]       calc_outC;
  logic              calc_oStall;

  calc_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready), .calc_inpA(calc_inpA), .calc_inpB(calc_inpB),
    .calc_inpOpType(calc_inpOpType), .calc_iValid(calc_iValid), .calc_iStall(calc_iStall),
    .calc_oValid(calc_oValid), .calc_outC(calc_outC), .calc_oStall(calc_oStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_calc(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [15:0] a16, b16;
    a16 = {8'h00, a};
    b16 = {8'h00, b};
    case (op)
      2'b00:   return a16 + b16;
      2'b01:   return a16 - b16;
      2'b10:   return a16 * b16;
      default: return (b16 == 16'h0) ? 16'h0 : a16 / b16;
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    end
    return -1;
  endfunction

  // Behavioural calc unit: oValid lat cycles after iValid first seen, held ov_len cycles
  int   lat = 1;
  int   ov_len = 1;
  bit   calc_hold = 0;
  initial begin
    int cnt;
    int left;
    cnt = 0;
    left = 0;
    calc_oValid = 1'b0;
    calc_outC = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        cnt = 0;
        calc_oValid = 1'b0;
      end else if (calc_oValid) begin
        left--;
        if (left == 0) begin
          calc_oValid = 1'b0;
          cnt = 0;
        end else begin
          calc_outC = 16'hDEAD;
        end
      end else if (calc_iValid && !calc_hold) begin
        if (cnt == lat) begin
          calc_oValid = 1'b1;
          calc_outC = ref_calc(calc_inpA, calc_inpB, calc_inpOpType);
          left = ov_len;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Scoreboard model state
  int              cyc = 0;
  bit              busy = 0;
  int              rr = 0;
  int              exp_idx = 0;
  logic [15:0]     exp_c = 0;
  bit              exp_err = 0;
  bit              timeout_mode = 0;
  int              grant_cyc = 0;
  int              lat_rec = 0;
  bit              rsp_seen = 0;
  int              resp_cnt = 0;
  logic            last_err = 0;
  logic [NREQ-1:0] acc_mask = '0;
  int              grants[$];
  logic [15:0]     rsps[$];

  // Compare process: checks every cycle against the model
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_vld;
    int g;
    cyc++;
    if (!rstn) begin
      busy = 0;
      rr = 0;
    end else begin
      chk("oStall", calc_oStall, (rsp_valid != 0) && !rsp_ready);
      if (busy) begin
        chk("ready_busy", req_ready, 0);
      end else begin
        exp_rdy = '0;
        g = pick(req_valid, rr);
        if (req_valid != 0 && !calc_iStall) exp_rdy[g] = 1'b1;
        chk("ready", req_ready, exp_rdy);
        if ((req_valid & req_ready) != 0) begin
          busy = 1;
          exp_idx = g;
          exp_c = timeout_mode ? 16'h0 : ref_calc(req_a[g*8 +: 8], req_b[g*8 +: 8], req_op[g*2 +: 2]);
          exp_err = timeout_mode;
          rr = (g + 1) % NREQ;
          grants.push_back(g);
          grant_cyc = cyc;
          rsp_seen = 0;
          acc_mask |= req_valid & req_ready;
        end
      end
      if (rsp_valid != 0) begin
        exp_vld = '0;
        if (busy) exp_vld[exp_idx] = 1'b1;
        chk("rsp_owner", rsp_valid, exp_vld);
        if (busy) begin
          chk("rsp_c", rsp_c, exp_c);
          chk("rsp_err", rsp_err, exp_err);
          if (!rsp_seen) lat_rec = cyc - grant_cyc;
          rsp_seen = 1;
          if (rsp_ready) begin
            busy = 0;
            resp_cnt++;
            rsps.push_back(rsp_c);
            last_err = rsp_err;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req_valid &= ~acc_mask;
    acc_mask = '0;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    req_valid[i] = 1'b1;
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_op[i*2 +: 2] = op;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || req_valid != 0) && n < 300) begin
      step();
      n++;
    end
    chk("idle_wait", busy || (req_valid != 0), 0);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (rsp_valid == 0 && n < 100) begin
      step();
      n++;
    end
    chk("rsp_wait", rsp_valid != 0, 1);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req_valid = '0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int n0;
    rstn = 1'b0;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 1'b1;
    calc_iStall = 1'b0;
    step();
    step();
    // Reset values with every requester asking
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_iValid", calc_iValid, 0);
    chk("rst_oStall", calc_oStall, 0);
    chk("rst_operands", {calc_inpA, calc_inpB, calc_inpOpType}, 0);
    rstn = 1'b1;
    req_valid = '0;
    step();

    // Single add from requester 0
    n0 = grants.size();
    set_req(0, 8'h05, 8'h05, 2'b00);
    wait_idle();
    chk("add_grants", grants.size() - n0, 1);
    chk("add_result", rsps[$], 16'h000A);
    chk("add_latency", lat_rec, 4);

    // Round-robin order from rr_ptr=0, then the next pair starting at 3
    do_reset();
    grants.delete();
    rsps.delete();
    set_req(0, 8'h03, 8'h04, 2'b10);
    set_req(2, 8'h10, 8'h03, 2'b01);
    wait_idle();
    set_req(1, 8'h07, 8'h11, 2'b10);
    set_req(3, 8'h16, 8'h00, 2'b11);
    wait_idle();
    chk("rr_count", grants.size(), 4);
    if (grants.size() == 4 && rsps.size() == 4) begin
      chk("rr_g0", grants[0], 0);
      chk("rr_g1", grants[1], 2);
      chk("rr_g2", grants[2], 3);
      chk("rr_g3", grants[3], 1);
      chk("rr_c0", rsps[0], 16'h000C);
      chk("rr_c1", rsps[1], 16'h000D);
      chk("div0_c", rsps[2], 16'h0000);
      chk("mul_c", rsps[3], 16'h0077);
    end
    chk("mul_err", last_err, 0);

    // Response held off for 3 cycles with another requester waiting
    rsp_ready = 1'b0;
    set_req(2, 8'h20, 8'h01, 2'b00);
    wait_rsp();
    set_req(0, 8'h01, 8'h02, 2'b00);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_oStall", calc_oStall, 1);
      chk("hold_rsp_c", rsp_c, 16'h0021);
      chk("hold_ready", req_ready, 0);
      step();
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("after_hold_c", rsps[$], 16'h0003);
    chk("after_hold_g", grants[$], 0);

    // calc_iStall blocks grants; grant lands in the cycle it falls
    calc_iStall = 1'b1;
    set_req(1, 8'h07, 8'h02, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("istall_ready", req_ready, 0);
    end
    calc_iStall = 1'b0;
    step();
    chk("istall_grant_cyc", grant_cyc, cyc);
    chk("istall_grant_idx", grants[$], 1);
    wait_idle();
    chk("istall_c", rsps[$], 16'h0005);

    // Lingering calc_oValid: DRAIN waits, no recapture; then back-to-back single requester
    lat = 3;
    ov_len = 3;
    set_req(1, 8'h09, 8'h03, 2'b11);
    wait_idle();
    chk("drain_latency", lat_rec, 8);
    chk("drain_c", rsps[$], 16'h0003);
    lat = 1;
    ov_len = 1;
    set_req(1, 8'h0A, 8'h0B, 2'b00);
    wait_idle();
    chk("b2b_grant", grants[$], 1);
    chk("b2b_c", rsps[$], 16'h0015);

`ifdef CALC_SCHED_TIMEOUT_EN
    // Watchdog expiry with calc never answering
    calc_hold = 1;
    timeout_mode = 1;
    set_req(2, 8'h01, 8'h01, 2'b00);
    wait_idle();
    chk("to_latency", lat_rec, TO + 1);
    chk("to_c", rsps[$], 16'h0000);
    chk("to_err", last_err, 1);
    timeout_mode = 0;
    calc_hold = 0;
`endif

    // Reset mid-ISSUE abandons the op
    calc_hold = 1;
    n0 = resp_cnt;
    set_req(0, 8'h02, 8'h02, 2'b00);
    step();
    step();
    chk("mid_iValid", calc_iValid, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_iValid", calc_iValid, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_operands", {calc_inpA, calc_inpB, calc_inpOpType}, 0);
    step();
    step();
    rstn = 1'b1;
    calc_hold = 0;
    for (int k = 0; k < 15; k++) step();
    chk("mid_rst_no_rsp", resp_cnt, n0);
    chk("mid_rst_idle_ready", req_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
